// File: rtl/dac_transmisor_pkg.sv
// Shared constants, DAC power-down mode codes and transmitter state encoding.
// Used by the serial DAC transmitter and its SCLK tick generator.
package dac_pkg;

  localparam int DATA_W  = 12;
  localparam int FRAME_W = 16;

  // Power-down field sent in bits [13:12] of every frame
  localparam logic [1:0] MODO_NORMAL  = 2'b00;
  localparam logic [1:0] MODO_PD_1K   = 2'b01;
  localparam logic [1:0] MODO_PD_100K = 2'b10;
  localparam logic [1:0] MODO_PD_HIZ  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/dac_transmisor_sclk_tick.sv
// SCLK half-period tick: one-cycle enable every DIV system clocks while en is high.
// Latency: first tick DIV cycles after en rises; counter forced to 0 whenever en is low.
// No backpressure: free-running while enabled.
module dac_sclk_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == CW'(DIV - 1));

  // Count 0..DIV-1 while enabled; held at zero otherwise so each frame starts aligned
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/dac_transmisor.sv
// SYNC-framed serial transmitter for the audio DAC: {2'b00, modo, sample}, MSB first.
// Latency: start edge to tx_listo = 1 + 34*DIV clk cycles; SYNC low for 32*DIV cycles.
// Starts are taken only in IDLE; requests while ocupado=1 are dropped, never queued.
module dac_transmisor #(
  parameter int DIV     = 4,
  parameter int DATA_W  = dac_pkg::DATA_W,
  parameter int FRAME_W = dac_pkg::FRAME_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inicio_tx,
  input  logic [DATA_W-1:0] paquete_bits,
  input  logic [1:0]        modo,
  output logic              SYNC,
  output logic              SCLK,
  output logic              dato_out,
  output logic              ocupado,
  output logic              tx_listo
);
  import dac_pkg::*;

  localparam int BCW = $clog2(FRAME_W + 1);

  state_e               state_q;
  logic [FRAME_W-1:0]   sr_q;
  logic [BCW-1:0]       bitcnt_q;
  logic                 fin_half_q;
  logic                 sync_q;
  logic                 sclk_q;
  logic                 dato_q;
  logic                 ocupado_q;
  logic                 listo_q;
  logic                 tick;
  logic [FRAME_W-1:0]   palabra;

  assign palabra = {2'b00, modo, paquete_bits};

  dac_sclk_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .tick (tick)
  );

  // Frame sequencer: IDLE -> TX (32 SCLK toggles) -> FIN (2 ticks of SYNC-high gap) -> IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      bitcnt_q   <= '0;
      fin_half_q <= 1'b0;
      sync_q     <= 1'b1;
      sclk_q     <= 1'b1;
      dato_q     <= 1'b0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sync_q    <= 1'b1;
          sclk_q    <= 1'b1;
          ocupado_q <= 1'b0;
          dato_q    <= 1'b0;
          if (inicio_tx) begin
            sr_q      <= palabra;
            bitcnt_q  <= BCW'(FRAME_W);
            state_q   <= ST_TX;
            sync_q    <= 1'b0;
            ocupado_q <= 1'b1;
            dato_q    <= palabra[FRAME_W-1];
          end
        end
        ST_TX: begin
          if (tick) begin
            if (sclk_q) begin
              // Falling toggle: the DAC samples the bit currently on dato_out
              sclk_q   <= 1'b0;
              bitcnt_q <= bitcnt_q - BCW'(1);
            end else begin
              sclk_q <= 1'b1;
              if (bitcnt_q != '0) begin
                dato_q <= sr_q[FRAME_W-2];
                sr_q   <= sr_q << 1;
              end else begin
                state_q    <= ST_FIN;
                sync_q     <= 1'b1;
                dato_q     <= 1'b0;
                fin_half_q <= 1'b0;
              end
            end
          end
        end
        ST_FIN: begin
          if (tick) begin
            if (fin_half_q) begin
              listo_q    <= 1'b1;
              ocupado_q  <= 1'b0;
              state_q    <= ST_IDLE;
              fin_half_q <= 1'b0;
            end else begin
              fin_half_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign SYNC     = sync_q;
  assign SCLK     = sclk_q;
  assign dato_out = dato_q;
  assign ocupado  = ocupado_q;
  assign tx_listo = listo_q;

endmodule

// File: doc/dac_transmisor.md
Name: dac_transmisor

Overview:
- Serial transmitter feeding the audio DAC. It is the output-side counterpart of the ADC capture path in the equalizer.
- Accepts a 12-bit processed sample plus a 2-bit power-down mode and frames them as a 16-bit SPI-style word: SYNC framed, MSB first, DAC samples on the falling edge of SCLK.
- SCLK is derived internally from the system clock through a tick enable. The block has no second clock domain.

Parameters:
- DIV, 4: system-clock cycles per SCLK half-period. Legal range is 1..255. SCLK frequency = clk/(2*DIV).
- DATA_W, 12: sample width in bits.
- FRAME_W, 16: bits per frame. Must equal DATA_W+4.

Ports:
- clk, input, 1: system clock. All logic is on its rising edge.
- rst, input, 1: synchronous, active-low reset. rst=0 at a rising clk edge resets the block.
- inicio_tx, input, 1: start request. Sampled only in IDLE.
- paquete_bits, input, 12: sample to send. Latched on the accepted start.
- modo, input, 2: DAC power-down bits (00 = normal). Latched together with paquete_bits.
- SYNC, output, 1: active-low frame select to the DAC.
- SCLK, output, 1: serial clock. Idles high.
- dato_out, output, 1: serial data, MSB first.
- ocupado, output, 1: high from start acceptance until tx_listo.
- tx_listo, output, 1: one-cycle pulse at frame completion.

Behaviour:
- Reset (rst=0 at any edge, including mid-frame) takes effect on that same edge:
  - SYNC=1, SCLK=1, dato_out=0, ocupado=0, tx_listo=0.
  - State = IDLE; shift register and counters cleared.
  - The aborted frame is abandoned and is never resumed.
- Frame word: {2'b00, modo, paquete_bits}, shifted out MSB first.
- Tick generator: counter 0..DIV-1, producing a 1-cycle tick when it wraps. It is held at 0 outside TX/FIN and restarts from 0 on start acceptance.
- State IDLE:
  - SYNC=1, SCLK=1, ocupado=0.
  - If inicio_tx=1, latch the word, load bit counter=16 and go to TX.
  - The next edge drives SYNC=0, ocupado=1 and dato_out=bit15.
- State TX: each tick toggles SCLK.
  - Falling toggle (1->0): the DAC samples dato_out here; decrement the bit counter.
  - Rising toggle (0->1): if bits remain, shift and drive the next bit on the same edge.
  - On the rising toggle after the 16th falling edge, go to FIN, drive SYNC=1 and set dato_out=0.
  - SYNC is low for exactly 32*DIV clk cycles.
- State FIN (SYNC-high gap):
  - Hold SYNC=1, SCLK=1 for 2*DIV cycles.
  - On the last cycle, pulse tx_listo=1 for exactly one cycle, drop ocupado and return to IDLE.
- Latency: inicio_tx edge to tx_listo edge = 1 + 34*DIV cycles (69 for DIV=2).
- Back-to-back frames: if inicio_tx is high in the cycle after tx_listo, the next frame starts. Minimum frame period = 1 + 34*DIV cycles.
- inicio_tx while ocupado=1 is ignored: no queueing, no effect on the current frame.
- Changes to paquete_bits or modo after acceptance do not affect the frame in flight.
- dato_out changes only on rising-SCLK toggles or on frame start. It is stable for ≥DIV cycles around each falling edge.
- Simultaneous rst=0 and inicio_tx=1: reset wins.

Decomposition:
- Shared package dac_pkg:
  - FRAME_W and DATA_W constants.
  - Mode codes: MODO_NORMAL=2'b00, MODO_PD_1K=2'b01, MODO_PD_100K=2'b10, MODO_PD_HIZ=2'b11.
  - State encoding: IDLE, TX, FIN.
- One sub-module, dac_sclk_tick: parameterized DIV counter with enable and synchronous active-low reset, producing the tick. It mirrors the frequency-divider role on the receive side but outputs an enable, not a clock.

Test Plan:
- DIV=2, paquete_bits=12'hABC, modo=00, 1-cycle inicio_tx:
  - Bench samples dato_out at 16 SCLK falling edges and captures 16'h0ABC.
  - SYNC is low for 64 cycles; tx_listo pulses exactly once at edge 69.
- DIV=1, modo=11, data=12'hFFF: captured word is 16'h3FFF; SCLK is clk/2; latency = 35 cycles.
- Hold inicio_tx=1 continuously with data alternating 12'h000 and 12'hFFF:
  - Frames go out back-to-back; each SYNC-high gap is 2*DIV cycles.
  - Captured words are 16'h0000 and 16'h0FFF in order.
- Pulse inicio_tx and change paquete_bits at mid-frame (after 8 falling edges): the in-flight word is unchanged and the extra start is ignored (exactly one tx_listo).
- Assert rst=0 after 5 falling edges:
  - Next edge gives SYNC=1, SCLK=1, dato_out=0, ocupado=0, with no tx_listo.
  - A new inicio_tx afterwards sends a complete, correct frame.
- Apply rst=0 and inicio_tx=1 in the same cycle: the block stays IDLE and SYNC stays 1.
